// File: rtl/ov7670_pixel_capture.sv
// OV7670 capture stage: YUV422 luma extraction, DECIM x DECIM decimation
// and linear frame-buffer write generation, with frame/line sync checks.
module ov7670_pixel_capture #(
  parameter int         ADDR_WIDTH = 15,
  parameter int         SRC_W      = 640,
  parameter int         SRC_H      = 480,
  parameter int         DECIM      = 4,
  parameter logic [7:0] THRESH     = 8'd64,
  parameter bit         Y_FIRST    = 1'b1
) (
  input  logic                  pclk,
  input  logic                  reset,
  input  logic                  v_sync,
  input  logic                  h_ref,
  input  logic [7:0]            data_in,
  output logic [7:0]            Y,
  output logic                  pixel,
  output logic [ADDR_WIDTH-1:0] write_addr,
  output logic                  we,
  output logic                  frame_done,
  output logic                  frame_err,
  output logic                  line_err
);

  localparam int OUT_W = SRC_W / DECIM;
  localparam int OUT_H = SRC_H / DECIM;
  localparam int CW = $clog2(SRC_W + 1);
  localparam int RW = $clog2(SRC_H + 1);
  localparam int DW = (DECIM > 1) ? $clog2(DECIM) : 1;

  localparam logic [ADDR_WIDTH-1:0] NPIX =
    ADDR_WIDTH'(OUT_W * OUT_H);
  localparam logic [CW-1:0] COL_END = CW'(SRC_W);
  localparam logic [RW-1:0] ROW_END = RW'(SRC_H);
  localparam logic [DW-1:0] D_LAST  = DW'(DECIM - 1);

  typedef enum logic [1:0] {
    S_SYNC,
    S_VBLANK,
    S_ACTIVE
  } state_t;

  state_t state, state_nxt;

  logic                  phase;
  logic                  h_ref_d;
  logic                  lerr_seen;
  logic                  rerr_seen;
  logic [CW-1:0]         col;
  logic [RW-1:0]         row;
  logic [DW-1:0]         cmod;
  logic [DW-1:0]         rmod;
  logic [ADDR_WIDTH-1:0] addr;
  logic [ADDR_WIDTH-1:0] addr_nxt;

  logic active, luma, col_ovf, row_ovf, keep;
  logic line_end, lerr_evt, rerr_evt;
  logic frame_end, done_evt, ferr_evt;

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) state <= S_SYNC;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    active    = 1'b0;
    luma      = 1'b0;
    col_ovf   = 1'b0;
    row_ovf   = 1'b0;
    keep      = 1'b0;
    line_end  = 1'b0;
    lerr_evt  = 1'b0;
    rerr_evt  = 1'b0;
    frame_end = 1'b0;
    done_evt  = 1'b0;
    ferr_evt  = 1'b0;
    addr_nxt  = addr;

    unique case (state)
      S_SYNC:   if (v_sync)  state_nxt = S_VBLANK;
      S_VBLANK: if (!v_sync) state_nxt = S_ACTIVE;
      S_ACTIVE: if (v_sync)  state_nxt = S_VBLANK;
      default:               state_nxt = S_SYNC;
    endcase

    active   = (state == S_ACTIVE);
    luma     = active && h_ref && (phase != Y_FIRST);
    col_ovf  = (col >= COL_END);
    row_ovf  = (row >= ROW_END);
    keep     = luma && !col_ovf && !row_ovf &&
               (cmod == '0) && (rmod == '0) &&
               (addr != NPIX);
    line_end = active && h_ref_d && !h_ref &&
               (col != '0);
    lerr_evt = luma && col_ovf && !lerr_seen;
    rerr_evt = luma && row_ovf && !rerr_seen;

    if (keep) addr_nxt = addr + ADDR_WIDTH'(1);

    // frame end is judged on the address after a coincident write
    frame_end = active && v_sync;
    done_evt  = frame_end && (addr_nxt == NPIX);
    ferr_evt  = !done_evt && (frame_end || rerr_evt);
  end

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      Y          <= '0;
      pixel      <= 1'b0;
      write_addr <= '0;
      we         <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      line_err   <= 1'b0;
      phase      <= 1'b0;
      h_ref_d    <= 1'b0;
      lerr_seen  <= 1'b0;
      rerr_seen  <= 1'b0;
      col        <= '0;
      row        <= '0;
      cmod       <= '0;
      rmod       <= '0;
      addr       <= '0;
    end else begin
      we         <= keep;
      frame_done <= done_evt;
      frame_err  <= ferr_evt;
      line_err   <= lerr_evt;
      h_ref_d    <= h_ref;
      phase      <= h_ref & ~phase;
      addr       <= addr_nxt;

      if (keep) begin
        Y          <= data_in;
        pixel      <= (data_in >= THRESH);
        write_addr <= addr;
      end

      if (state == S_VBLANK) begin
        phase     <= 1'b0;
        col       <= '0;
        row       <= '0;
        cmod      <= '0;
        rmod      <= '0;
        addr      <= '0;
        lerr_seen <= 1'b0;
        rerr_seen <= 1'b0;
      end else if (active) begin
        if (luma && !col_ovf) begin
          col  <= col + CW'(1);
          cmod <= (cmod == D_LAST) ? '0 : cmod + DW'(1);
        end
        if (lerr_evt) lerr_seen <= 1'b1;
        if (rerr_evt) rerr_seen <= 1'b1;
        if (line_end) begin
          col       <= '0;
          cmod      <= '0;
          lerr_seen <= 1'b0;
          if (!row_ovf) begin
            row  <= row + RW'(1);
            rmod <= (rmod == D_LAST) ? '0 : rmod + DW'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ov7670_pixel_capture.sv
// Bench for ov7670_pixel_capture: two instances (luma-first and chroma-first)
// share one randomised camera stream and a row/column reference model.
module tb_ov7670_pixel_capture;

  localparam int W  = 32;
  localparam int H  = 24;
  localparam int D  = 4;
  localparam int NP = (W / D) * (H / D);

  typedef struct {
    logic [7:0]  y;
    logic [14:0] a;
    int          cyc;
  } wr_t;

  logic        pclk = 1'b0;
  logic        reset;
  logic        v_sync;
  logic        h_ref;
  logic [7:0]  data_in;

  logic [7:0]  y_w   [2];
  logic        pix_w [2];
  logic [14:0] a_w   [2];
  logic        we_w  [2];
  logic        fd_w  [2];
  logic        fe_w  [2];
  logic        le_w  [2];

  int nchk = 0;
  int nerr = 0;
  int cyc  = 0;

  wr_t q0[$];
  wr_t q1[$];

  int  m_row[2], m_addr[2];
  bit  m_lerr[2], m_rovf[2];
  bit  m_cap = 1'b0;
  int  m_line = 0;
  int  exp_done[2] = '{0, 0};
  int  exp_ferr[2] = '{0, 0};
  int  exp_lerr[2] = '{0, 0};
  int  got_done[2] = '{0, 0};
  int  got_ferr[2] = '{0, 0};
  int  got_lerr[2] = '{0, 0};
  int  nwe[2]      = '{0, 0};

  logic [7:0]  log_y [2][4];
  logic        log_p [2][4];
  logic [14:0] log_a [2][4];
  int          log_n [2] = '{4, 4};
  logic [7:0]  held_y[2];
  logic [14:0] held_a[2];

  ov7670_pixel_capture #(
    .ADDR_WIDTH(15), .SRC_W(W), .SRC_H(H),
    .DECIM(D), .THRESH(8'd64), .Y_FIRST(1'b1)
  ) u_dut1 (
    .pclk(pclk), .reset(reset),
    .v_sync(v_sync), .h_ref(h_ref),
    .data_in(data_in), .Y(y_w[1]),
    .pixel(pix_w[1]), .write_addr(a_w[1]),
    .we(we_w[1]), .frame_done(fd_w[1]),
    .frame_err(fe_w[1]), .line_err(le_w[1])
  );

  ov7670_pixel_capture #(
    .ADDR_WIDTH(15), .SRC_W(W), .SRC_H(H),
    .DECIM(D), .THRESH(8'd64), .Y_FIRST(1'b0)
  ) u_dut0 (
    .pclk(pclk), .reset(reset),
    .v_sync(v_sync), .h_ref(h_ref),
    .data_in(data_in), .Y(y_w[0]),
    .pixel(pix_w[0]), .write_addr(a_w[0]),
    .we(we_w[0]), .frame_done(fd_w[0]),
    .frame_err(fe_w[0]), .line_err(le_w[0])
  );

  always #5 pclk = ~pclk;

  always @(posedge pclk) cyc = cyc + 1;

  task automatic check(string tag,
                       logic [31:0] got,
                       logic [31:0] exp);
    nchk++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d",
             tag, got, exp);
    end
  endtask

  function automatic logic [7:0] bval(int mode, int seed,
                                      int r, int i);
    logic [31:0] h;
    int c;
    c = i / 2;
    h = (seed ^ (r * 7919) ^ (i * 104729)) * 32'd2654435761;
    case (mode)
      0: return (i % 2 == 0) ? 8'(c) : 8'h80;
      2: return (i % 4 == 1) ? 8'h10 :
                (i % 4 == 3) ? 8'h20 : 8'h80;
      3: begin
        if (i % 2 == 0 && c % 8 == 0) return 8'd63;
        if (i % 2 == 0 && c % 8 == 4) return 8'd64;
        return h[23:16];
      end
      default: return h[23:16];
    endcase
  endfunction

  task automatic push(int d, logic [7:0] y, int a, int c);
    wr_t e;
    e.y = y;
    e.a = 15'(a);
    e.cyc = c;
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  // c: luma index within the line for instance d
  task automatic model_luma(int d, int c, logic [7:0] y);
    if (c >= W) begin
      if (!m_lerr[d]) begin
        exp_lerr[d]++;
        m_lerr[d] = 1'b1;
      end
    end else if (m_row[d] >= H) begin
      if (!m_rovf[d]) begin
        exp_ferr[d]++;
        m_rovf[d] = 1'b1;
      end
    end else if (m_row[d] % D == 0 && c % D == 0 &&
                 m_addr[d] < NP) begin
      push(d, y, m_addr[d], cyc + 1);
      m_addr[d]++;
    end
  endtask

  task automatic frame_end_model();
    for (int d = 0; d < 2; d++)
      if (m_addr[d] == NP) exp_done[d]++;
      else                 exp_ferr[d]++;
  endtask

  task automatic vsync_pulse(bit eval);
    if (m_cap && eval) frame_end_model();
    repeat (4) begin
      @(negedge pclk);
      v_sync = 1'b1;
      h_ref  = 1'b0;
    end
    repeat (4) begin
      @(negedge pclk);
      v_sync = 1'b0;
    end
    m_cap  = 1'b1;
    m_line = 0;
    m_row  = '{0, 0};
    m_addr = '{0, 0};
    m_rovf = '{0, 0};
  endtask

  task automatic drive_line(int nbytes, int mode,
                            int seed, bit vs_last);
    int nl[2];
    int gap;
    nl = '{0, 0};
    m_lerr = '{0, 0};
    for (int i = 0; i < nbytes; i++) begin
      @(negedge pclk);
      h_ref   = 1'b1;
      data_in = bval(mode, seed, m_line, i);
      v_sync  = vs_last && (i == nbytes - 1);
      for (int d = 0; d < 2; d++)
        if ((i % 2) == (d == 1 ? 0 : 1)) begin
          if (m_cap) model_luma(d, nl[d], data_in);
          nl[d]++;
        end
    end
    gap = $urandom_range(4, 1);
    for (int g = 0; g < gap; g++) begin
      @(negedge pclk);
      h_ref   = 1'b0;
      data_in = 8'($urandom);
    end
    for (int d = 0; d < 2; d++)
      if (nl[d] > 0 && m_row[d] < H) m_row[d]++;
    m_line++;
    if (vs_last && m_cap) frame_end_model();
  endtask

  task automatic drive_frame(int nl, int mode,
                             int seed, int long_row);
    for (int r = 0; r < nl; r++)
      drive_line(r == long_row ? 2 * (W + 15) : 2 * W,
                 mode, seed, 1'b0);
  endtask

  task automatic check_frame(string tag);
    check({tag, "_q0_left"}, q0.size(), 0);
    check({tag, "_q1_left"}, q1.size(), 0);
    for (int d = 0; d < 2; d++) begin
      check({tag, "_done"}, got_done[d], exp_done[d]);
      check({tag, "_ferr"}, got_ferr[d], exp_ferr[d]);
      check({tag, "_lerr"}, got_lerr[d], exp_lerr[d]);
    end
  endtask

  always @(negedge pclk) begin
    wr_t e;
    for (int d = 0; d < 2; d++) begin
      if (fd_w[d] === 1'b1) got_done[d]++;
      if (fe_w[d] === 1'b1) got_ferr[d]++;
      if (le_w[d] === 1'b1) got_lerr[d]++;
      if (fd_w[d] === 1'b1 || fe_w[d] === 1'b1)
        check("done_err_excl", 32'(fd_w[d] & fe_w[d]), 0);
      if (reset) begin
        held_y[d] = 8'd0;
        held_a[d] = 15'd0;
      end else if (we_w[d] === 1'b1) begin
        nwe[d]++;
        held_y[d] = y_w[d];
        held_a[d] = a_w[d];
        if (log_n[d] < 4) begin
          log_y[d][log_n[d]] = y_w[d];
          log_p[d][log_n[d]] = pix_w[d];
          log_a[d][log_n[d]] = a_w[d];
          log_n[d]++;
        end
        if ((d == 0 ? q0.size() : q1.size()) == 0) begin
          check("unexpected_we", 1, 0);
        end else begin
          e = (d == 0) ? q0.pop_front() : q1.pop_front();
          check("wr_y", y_w[d], e.y);
          check("wr_pixel", pix_w[d], e.y >= 8'd64);
          check("wr_addr", a_w[d], e.a);
          check("we_latency", cyc, e.cyc);
        end
      end else begin
        check("hold_y", y_w[d], held_y[d]);
        check("hold_addr", a_w[d], held_a[d]);
      end
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seed, w0, w1, b0, b1, b2, b3;
    reset   = 1'b1;
    v_sync  = 1'b0;
    h_ref   = 1'b0;
    data_in = 8'd0;
    repeat (3) @(negedge pclk);
    for (int d = 0; d < 2; d++) begin
      check("rst_we", we_w[d], 0);
      check("rst_y", y_w[d], 0);
      check("rst_pixel", pix_w[d], 0);
      check("rst_addr", a_w[d], 0);
      check("rst_done", fd_w[d], 0);
      check("rst_ferr", fe_w[d], 0);
      check("rst_lerr", le_w[d], 0);
    end
    reset = 1'b0;

    // full frame, luma = column index
    vsync_pulse(1'b1);
    log_n = '{0, 0};
    w1 = nwe[1];
    b0 = got_done[1];
    drive_frame(H, 0, 0, -1);
    vsync_pulse(1'b1);
    check_frame("t1");
    check("t1_nwe", nwe[1] - w1, NP);
    check("t1_done_once", got_done[1] - b0, 1);
    for (int k = 0; k < 4; k++) begin
      check("t1_row0_y", log_y[1][k], 4 * k);
      check("t1_row0_addr", log_a[1][k], k);
    end

    // reset released mid-frame while h_ref toggles
    @(negedge pclk);
    reset = 1'b1;
    m_cap = 1'b0;
    w0 = nwe[0] + nwe[1];
    fork
      begin
        repeat (5) @(negedge pclk);
        reset = 1'b0;
      end
    join_none
    seed = $urandom;
    drive_frame(6, 1, seed, -1);
    check("t2_no_we", nwe[0] + nwe[1] - w0, 0);
    vsync_pulse(1'b1);
    log_n = '{0, 0};
    drive_frame(H, 1, seed, -1);
    vsync_pulse(1'b1);
    check_frame("t2");
    check("t2_first_addr1", log_a[1][0], 0);
    check("t2_first_addr0", log_a[0][0], 0);

    // threshold boundary 63 / 64
    log_n = '{0, 0};
    drive_frame(H, 3, $urandom, -1);
    vsync_pulse(1'b1);
    check_frame("t3");
    check("t3_y63", log_y[1][0], 63);
    check("t3_pix63", log_p[1][0], 0);
    check("t3_y64", log_y[1][1], 64);
    check("t3_pix64", log_p[1][1], 1);

    // over-long line on a kept row
    w1 = nwe[1];
    b1 = got_lerr[1];
    drive_frame(H, 1, $urandom, 4);
    vsync_pulse(1'b1);
    check_frame("t4");
    check("t4_lerr_once", got_lerr[1] - b1, 1);
    check("t4_nwe", nwe[1] - w1, NP);

    // short frame, then full frame restarts at 0
    b0 = got_done[1];
    b1 = got_ferr[1];
    drive_frame(10, 1, $urandom, -1);
    vsync_pulse(1'b1);
    check_frame("t5");
    check("t5_ferr_once", got_ferr[1] - b1, 1);
    check("t5_no_done", got_done[1] - b0, 0);
    log_n = '{0, 0};
    drive_frame(H, 1, $urandom, -1);
    vsync_pulse(1'b1);
    check_frame("t5b");
    check("t5_restart_addr", log_a[1][0], 0);

    // chroma-first byte order
    log_n = '{0, 0};
    drive_frame(H, 2, 0, -1);
    vsync_pulse(1'b1);
    check_frame("t6");
    check("t6_y_col0", log_y[0][0], 8'h10);
    check("t6_y_col4", log_y[0][1], 8'h10);

    // excess lines are dropped
    b1 = got_ferr[1];
    drive_frame(H + 3, 1, $urandom, -1);
    vsync_pulse(1'b1);
    check_frame("t7");
    check("t7_ferr_once", got_ferr[1] - b1, 1);

    // v_sync rises on the last kept byte
    b0 = got_done[1];
    b1 = got_ferr[0];
    seed = $urandom;
    drive_frame(H - 4, 1, seed, -1);
    drive_line(2 * (W - D) + 1, 1, seed, 1'b1);
    vsync_pulse(1'b0);
    check_frame("t8");
    check("t8_done1", got_done[1] - b0, 1);
    check("t8_ferr0", got_ferr[0] - b1, 1);

    // reset in the middle of an active frame
    drive_frame(8, 1, $urandom, -1);
    @(negedge pclk);
    reset = 1'b1;
    m_cap = 1'b0;
    repeat (3) @(negedge pclk);
    reset = 1'b0;
    b2 = got_done[1];
    b3 = got_ferr[1];
    w0 = nwe[0] + nwe[1];
    drive_frame(4, 1, $urandom, -1);
    check("t9_no_we", nwe[0] + nwe[1] - w0, 0);
    vsync_pulse(1'b1);
    check("t9_no_evt", got_done[1] + got_ferr[1] - b2 - b3, 0);
    log_n = '{0, 0};
    drive_frame(H, 1, $urandom, -1);
    vsync_pulse(1'b1);
    check_frame("t9");
    check("t9_first_addr", log_a[1][0], 0);

    repeat (4) @(negedge pclk);
    $display("Simulation finished: %0d checks, %0d errors",
             nchk, nerr);
    $finish;
  end

endmodule
